// File: rtl/clock_step_controller_pkg.sv
// Shared types for the SAP-1 clock step controller.
// Contents:
//   ctrl_state_t - controller state encoding; also driven out on state_o.
//   cnt_width()  - counter width for a modulus; never returns less than 1.
package clk_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    STEP   = 3'd1,
    RUN    = 3'd2,
    HALTED = 3'd3,
    RESET  = 3'd4
  } ctrl_state_t;

  // $clog2(1) is 0, which is not a legal vector width.
  function automatic int cnt_width(input int modulus);
    return (modulus < 2) ? 1 : $clog2(modulus);
  endfunction

endpackage

// File: rtl/clock_step_controller_if.sv
// Event/status bundle between the board front end and the clock step controller.
// Signals:
//   step_evt, run_evt, rst_evt - one-cycle button press pulses from the debouncers
//   halt                       - CPU HLT level
//   cpu_tick, cpu_rst          - CPU clock enable and synchronous reset
//   running, halted, state_o   - LED and debug status
// Modports: master drives the events and reads status; slave is the controller.
interface clock_step_controller_if;
  import clk_ctrl_pkg::*;

  logic        step_evt;
  logic        run_evt;
  logic        rst_evt;
  logic        halt;
  logic        cpu_tick;
  logic        cpu_rst;
  logic        running;
  logic        halted;
  ctrl_state_t state_o;

  modport master (
    output step_evt, run_evt, rst_evt, halt,
    input  cpu_tick, cpu_rst, running, halted, state_o
  );

  modport slave (
    input  step_evt, run_evt, rst_evt, halt,
    output cpu_tick, cpu_rst, running, halted, state_o
  );
endinterface

// File: rtl/clock_step_controller_tick_divider.sv
// RUN-mode rate divider. It counts 0..RUN_DIV-1 while en is high and then wraps.
// Ports:
//   clk, clr   - system clock; asynchronous active-low reset
//   en         - count this cycle
//   sync_clear - force the count to 0 at the next edge; wins over counting
//   wrap       - combinational: en is high and the count is at its last value
module tick_divider
  import clk_ctrl_pkg::*;
#(
  parameter int RUN_DIV = 5_000_000
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  input  logic sync_clear,
  output logic wrap
);

  localparam int            W    = cnt_width(RUN_DIV);
  localparam logic [W-1:0]  LAST = W'(RUN_DIV - 1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    wrap    = en && (count_q == LAST);
    count_d = count_q;
    if (sync_clear || wrap) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/clock_step_controller.sv
// Controls the CPU clock enable for the SAP-1 FPGA build: single-step, free-run at
// 1/RUN_DIV, stop on HLT, and a timed CPU reset pulse. All outputs are registered.
// Ports:
//   clk, clr - system clock; asynchronous active-low reset
//   bus      - event inputs and CPU/status outputs (slave side)
//
// state  | meaning
// IDLE   | stopped, waiting for a step or run press
// STEP   | single cycle; cpu_tick is high
// RUN    | free-running; a tick follows each divider wrap
// HALTED | CPU executed HLT; only a reset press leaves this state
// RESET  | cpu_rst is held high for RST_CYCLES cycles, then IDLE
module clock_step_controller
  import clk_ctrl_pkg::*;
#(
  parameter int RUN_DIV    = 5_000_000,
  parameter int RST_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    clr,
  clock_step_controller_if.slave  bus
);

  localparam int            RW       = cnt_width(RST_CYCLES);
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);

  ctrl_state_t   state_q, state_d;
  logic [RW-1:0] rst_cnt_q, rst_cnt_d;
  logic          cpu_tick_q, cpu_tick_d;
  logic          cpu_rst_q, cpu_rst_d;
  logic          running_q, running_d;
  logic          halted_q, halted_d;
  logic          div_en, div_clear, div_wrap;

  assign div_en = (state_q == RUN);

  tick_divider #(.RUN_DIV(RUN_DIV)) u_tick_divider (
    .clk        (clk),
    .clr        (clr),
    .en         (div_en),
    .sync_clear (div_clear),
    .wrap       (div_wrap)
  );

  always_comb begin
    state_d    = state_q;
    rst_cnt_d  = rst_cnt_q;
    cpu_tick_d = 1'b0;
    div_clear  = 1'b0;

    if (bus.rst_evt) begin
      // A reset press from any state, including RESET itself, restarts the pulse.
      state_d   = RESET;
      rst_cnt_d = '0;
    end else begin
      case (state_q)
        RESET: begin
          if (rst_cnt_q == RST_LAST) begin
            state_d   = IDLE;
            rst_cnt_d = '0;
          end else begin
            rst_cnt_d = rst_cnt_q + RW'(1);
          end
        end
        HALTED: begin
          state_d = HALTED;
        end
        default: begin
          if (bus.halt) begin
            state_d = HALTED;
          end else begin
            case (state_q)
              IDLE: begin
                if (bus.run_evt) begin
                  state_d   = RUN;
                  div_clear = 1'b1;
                end else if (bus.step_evt) begin
                  state_d    = STEP;
                  cpu_tick_d = 1'b1;
                end
              end
              RUN: begin
                // Stopping on the wrap edge suppresses that tick.
                if (bus.run_evt) begin
                  state_d = IDLE;
                end else if (div_wrap) begin
                  cpu_tick_d = 1'b1;
                end
              end
              default: begin
                state_d = IDLE;
              end
            endcase
          end
        end
      endcase
    end

    cpu_rst_d = (state_d == RESET);
    running_d = (state_d == RUN);
    halted_d  = (state_d == HALTED);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q    <= IDLE;
      rst_cnt_q  <= '0;
      cpu_tick_q <= 1'b0;
      cpu_rst_q  <= 1'b0;
      running_q  <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rst_cnt_q  <= rst_cnt_d;
      cpu_tick_q <= cpu_tick_d;
      cpu_rst_q  <= cpu_rst_d;
      running_q  <= running_d;
      halted_q   <= halted_d;
    end
  end

  assign bus.cpu_tick = cpu_tick_q;
  assign bus.cpu_rst  = cpu_rst_q;
  assign bus.running  = running_q;
  assign bus.halted   = halted_q;
  assign bus.state_o  = state_q;

endmodule

// File: tb/tb_clock_step_controller.sv
// Directed bench for clock_step_controller with RUN_DIV=4 and RST_CYCLES=3.
// Cycle n spans negedge n to negedge n+1. At negedge n the bench checks the
// outputs for cycle n, then applies the inputs that the posedge ending cycle n samples.
module tb_clock_step_controller;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  clock_step_controller_if bus();

  clock_step_controller #(.RUN_DIV(4), .RST_CYCLES(3)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Inputs are packed as {step, run, rst, halt}.
  localparam logic [3:0] I_NONE = 4'b0000;
  localparam logic [3:0] I_STEP = 4'b1000;
  localparam logic [3:0] I_RUN  = 4'b0100;
  localparam logic [3:0] I_RST  = 4'b0010;
  localparam logic [3:0] I_HALT = 4'b0001;
  // Outputs are packed as {tick, cpu_rst, running, halted, state[2:0]}.
  localparam logic [6:0] E_IDLE = 7'b0000_000;
  localparam logic [6:0] E_STEP = 7'b1000_001;
  localparam logic [6:0] E_RUN  = 7'b0010_010;
  localparam logic [6:0] E_TICK = 7'b1010_010;
  localparam logic [6:0] E_HALT = 7'b0001_011;
  localparam logic [6:0] E_RST  = 7'b0100_100;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %07b expected %07b", tag, got[6:0], exp[6:0]);
    end
  endtask

  function automatic logic [6:0] outs();
    return {bus.cpu_tick, bus.cpu_rst, bus.running, bus.halted, 3'(bus.state_o)};
  endfunction

  task automatic vec(input string tag, input int c, input logic [3:0] in_v,
                     input logic [6:0] exp_v);
    check($sformatf("%s c%0d", tag, c), 32'(outs()), 32'(exp_v));
    {bus.step_evt, bus.run_evt, bus.rst_evt, bus.halt} = in_v;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] in_v;
    logic [6:0] ex;
    {bus.step_evt, bus.run_evt, bus.rst_evt, bus.halt} = I_NONE;
    #2 clr = 1'b0;
    repeat (3) @(negedge clk);
    check("clr_low", 32'(outs()), 32'(E_IDLE));
    clr = 1'b1;

    // Reset then idle.
    for (int c = 0; c < 20; c++) vec("idle", c, I_NONE, E_IDLE);

    // Single steps; the step press during STEP (c11) is dropped.
    for (int c = 0; c < 14; c++) begin
      in_v = (c == 5 || c == 10 || c == 11) ? I_STEP : I_NONE;
      ex   = (c == 6 || c == 11) ? E_STEP : E_IDLE;
      vec("step", c, in_v, ex);
    end

    // Run: ticks at 5 and 9; the stop press lands on the wrap edge, so no tick at 13.
    for (int c = 0; c < 16; c++) begin
      in_v = (c == 0 || c == 12) ? I_RUN : (c == 6) ? I_STEP : I_NONE;
      if (c >= 1 && c <= 12) ex = (c == 5 || c == 9) ? E_TICK : E_RUN;
      else                   ex = E_IDLE;
      vec("run", c, in_v, ex);
    end

    // Halt at c7; step/run presses are ignored during and after halt, and HALTED holds after halt drops.
    for (int c = 0; c < 17; c++) begin
      in_v = I_NONE;
      if (c == 0 || c == 10 || c == 13) in_v |= I_RUN;
      if (c == 9 || c == 14)            in_v |= I_STEP;
      if (c >= 7 && c <= 11)            in_v |= I_HALT;
      if (c == 0)                       ex = E_IDLE;
      else if (c <= 7)                  ex = (c == 5) ? E_TICK : E_RUN;
      else                              ex = E_HALT;
      vec("halt", c, in_v, ex);
    end

    // CPU reset from HALTED; reset beats a same-cycle run press; a second reset press restarts the pulse; halt is ignored in RESET.
    for (int c = 0; c < 15; c++) begin
      in_v = I_NONE;
      if (c == 0 || c == 8)  in_v = I_RST;
      if (c == 6)            in_v = I_RST | I_RUN;
      if (c == 9 || c == 10) in_v = I_HALT;
      if (c == 0)                                       ex = E_HALT;
      else if ((c >= 1 && c <= 3) || (c >= 7 && c <= 11)) ex = E_RST;
      else                                              ex = E_IDLE;
      vec("rst", c, in_v, ex);
    end

    // Asynchronous reset between ticks, then stays idle without a new event.
    for (int c = 0; c < 7; c++) begin
      in_v = (c == 0) ? I_RUN : I_NONE;
      ex   = (c == 0) ? E_IDLE : (c == 5) ? E_TICK : E_RUN;
      vec("arst", c, in_v, ex);
    end
    check("arst pre", 32'(outs()), 32'(E_RUN));
    #1 clr = 1'b0;
    #1 check("arst async", 32'(outs()), 32'(E_IDLE));
    @(negedge clk);
    check("arst held", 32'(outs()), 32'(E_IDLE));
    clr = 1'b1;
    for (int c = 0; c < 10; c++) vec("post_arst", c, I_NONE, E_IDLE);

    // Halt on a wrap edge (c4) suppresses the tick.
    for (int c = 0; c < 9; c++) begin
      in_v = (c == 0) ? I_RUN : (c == 4) ? I_HALT : I_NONE;
      ex   = (c == 0) ? E_IDLE : (c <= 4) ? E_RUN : E_HALT;
      vec("halt_wrap", c, in_v, ex);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
